// File: rtl/memreq_router_pkg.sv
// Shared definitions for the memory request router: FSM state encoding and
// Wishbone word-address LSB derivation (also used by dcache properties).
package memreq_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CFWD  = 2'd1,
    ST_WBREQ = 2'd2,
    ST_WBACK = 2'd3
  } mr_state_e;

  function automatic int unsigned wblsb(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/iscachable.sv
// Address classifier: an address is cachable if it falls in any enabled
// region (a region with a zero mask is disabled).
module iscachable #(
  parameter int unsigned    AW         = 32,
  parameter logic [AW-1:0]  SDRAM_ADDR = '0,
  parameter logic [AW-1:0]  SDRAM_MASK = '0,
  parameter logic [AW-1:0]  BKRAM_ADDR = 32'h1000_0000,
  parameter logic [AW-1:0]  BKRAM_MASK = 32'h1000_0000,
  parameter logic [AW-1:0]  FLASH_ADDR = '0,
  parameter logic [AW-1:0]  FLASH_MASK = '0
) (
  input  logic [AW-1:0] i_addr,
  output logic          o_cachable
);

  always_comb begin
    o_cachable = 1'b0;
    if ((SDRAM_MASK != '0) && ((i_addr & SDRAM_MASK) == SDRAM_ADDR))
      o_cachable = 1'b1;
    if ((BKRAM_MASK != '0) && ((i_addr & BKRAM_MASK) == BKRAM_ADDR))
      o_cachable = 1'b1;
    if ((FLASH_MASK != '0) && ((i_addr & FLASH_MASK) == FLASH_ADDR))
      o_cachable = 1'b1;
  end

endmodule

// File: rtl/memreq_router.sv
// Routes CPU memory requests: cachable ones go through one registered stage
// to the dcache, non-cachable ones run as single Wishbone transactions.
module memreq_router
  import memreq_router_pkg::*;
#(
  parameter int unsigned    AW         = 32,
  parameter int unsigned    DW         = 32,
  parameter logic [AW-1:0]  SDRAM_ADDR = '0,
  parameter logic [AW-1:0]  SDRAM_MASK = '0,
  parameter logic [AW-1:0]  BKRAM_ADDR = 32'h1000_0000,
  parameter logic [AW-1:0]  BKRAM_MASK = 32'h1000_0000,
  parameter logic [AW-1:0]  FLASH_ADDR = '0,
  parameter logic [AW-1:0]  FLASH_MASK = '0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_stb,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_addr,
  input  logic [DW-1:0]            i_data,
  input  logic [DW/8-1:0]          i_sel,
  output logic                     o_busy,
  output logic                     o_valid,
  output logic                     o_err,
  output logic [DW-1:0]            o_rdata,
  output logic                     o_cache_stb,
  output logic                     o_cache_we,
  output logic [AW-1:0]            o_cache_addr,
  output logic [DW-1:0]            o_cache_data,
  output logic [DW/8-1:0]          o_cache_sel,
  input  logic                     i_cache_stall,
  input  logic                     i_cache_busy,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [AW-wblsb(DW)-1:0]  o_wb_addr,
  output logic [DW-1:0]            o_wb_data,
  output logic [DW/8-1:0]          o_wb_sel,
  input  logic                     i_wb_stall,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic [DW-1:0]            i_wb_data
);

  localparam int unsigned WBLSB = wblsb(DW);

  mr_state_e              state_q, state_d;
  logic                   cache_stb_q, cache_stb_d;
  logic                   cache_we_q, cache_we_d;
  logic [AW-1:0]          cache_addr_q, cache_addr_d;
  logic [DW-1:0]          cache_data_q, cache_data_d;
  logic [DW/8-1:0]        cache_sel_q, cache_sel_d;
  logic                   wb_cyc_q, wb_cyc_d;
  logic                   wb_stb_q, wb_stb_d;
  logic                   wb_we_q, wb_we_d;
  logic [AW-WBLSB-1:0]    wb_addr_q, wb_addr_d;
  logic [DW-1:0]          wb_data_q, wb_data_d;
  logic [DW/8-1:0]        wb_sel_q, wb_sel_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [DW-1:0]          rdata_q, rdata_d;

  logic cachable;
  logic busy;
  logic accept;

  iscachable #(
    .AW         (AW),
    .SDRAM_ADDR (SDRAM_ADDR),
    .SDRAM_MASK (SDRAM_MASK),
    .BKRAM_ADDR (BKRAM_ADDR),
    .BKRAM_MASK (BKRAM_MASK),
    .FLASH_ADDR (FLASH_ADDR),
    .FLASH_MASK (FLASH_MASK)
  ) u_iscachable (
    .i_addr     (i_addr),
    .o_cachable (cachable)
  );

  // Uncached ops wait for the dcache to drain so results stay in order.
  always_comb begin
    busy = 1'b0;
    if ((state_q == ST_CFWD) && i_cache_stall)
      busy = 1'b1;
    if ((state_q == ST_WBREQ) || (state_q == ST_WBACK))
      busy = 1'b1;
    if (i_stb && !cachable && (i_cache_busy || cache_stb_q))
      busy = 1'b1;
  end

  assign accept = i_stb && !busy;

  always_comb begin
    state_d      = state_q;
    cache_stb_d  = cache_stb_q;
    cache_we_d   = cache_we_q;
    cache_addr_d = cache_addr_q;
    cache_data_d = cache_data_q;
    cache_sel_d  = cache_sel_q;
    wb_cyc_d     = wb_cyc_q;
    wb_stb_d     = wb_stb_q;
    wb_we_d      = wb_we_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    wb_sel_d     = wb_sel_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    rdata_d      = rdata_q;

    unique case (state_q)
      ST_IDLE, ST_CFWD: begin
        if ((state_q == ST_CFWD) && !i_cache_stall) begin
          cache_stb_d = 1'b0;
          state_d     = ST_IDLE;
        end
        if (accept) begin
          if (cachable) begin
            cache_stb_d  = 1'b1;
            cache_we_d   = i_we;
            cache_addr_d = i_addr;
            cache_data_d = i_data;
            cache_sel_d  = i_sel;
            state_d      = ST_CFWD;
          end else begin
            wb_cyc_d  = 1'b1;
            wb_stb_d  = 1'b1;
            wb_we_d   = i_we;
            wb_addr_d = i_addr[AW-1:WBLSB];
            wb_data_d = i_data;
            wb_sel_d  = i_sel;
            state_d   = ST_WBREQ;
          end
        end
      end
      ST_WBREQ, ST_WBACK: begin
        if (i_wb_err || i_wb_ack) begin
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
          state_d  = ST_IDLE;
          err_d    = i_wb_err;
          valid_d  = !i_wb_err;
          if (!i_wb_err && !wb_we_q)
            rdata_d = i_wb_data;
        end else if ((state_q == ST_WBREQ) && !i_wb_stall) begin
          wb_stb_d = 1'b0;
          state_d  = ST_WBACK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      cache_stb_q  <= 1'b0;
      cache_we_q   <= 1'b0;
      cache_addr_q <= '0;
      cache_data_q <= '0;
      cache_sel_q  <= '0;
      wb_cyc_q     <= 1'b0;
      wb_stb_q     <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      wb_sel_q     <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cache_stb_q  <= cache_stb_d;
      cache_we_q   <= cache_we_d;
      cache_addr_q <= cache_addr_d;
      cache_data_q <= cache_data_d;
      cache_sel_q  <= cache_sel_d;
      wb_cyc_q     <= wb_cyc_d;
      wb_stb_q     <= wb_stb_d;
      wb_we_q      <= wb_we_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      wb_sel_q     <= wb_sel_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign o_busy       = busy;
  assign o_valid      = valid_q;
  assign o_err        = err_q;
  assign o_rdata      = rdata_q;
  assign o_cache_stb  = cache_stb_q;
  assign o_cache_we   = cache_we_q;
  assign o_cache_addr = cache_addr_q;
  assign o_cache_data = cache_data_q;
  assign o_cache_sel  = cache_sel_q;
  assign o_wb_cyc     = wb_cyc_q;
  assign o_wb_stb     = wb_stb_q;
  assign o_wb_we      = wb_we_q;
  assign o_wb_addr    = wb_addr_q;
  assign o_wb_data    = wb_data_q;
  assign o_wb_sel     = wb_sel_q;

endmodule
